// File: rtl/laser500_ram_arbiter.sv
`default_nettype none
// ============================================================================
// laser500_ram_arbiter : shares one 8-bit SDRAM port among video, CPU and download
// Revision 1.0
// ============================================================================
module laser500_ram_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int ACC_CYCLES = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              F14M,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_ack,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rd,
  output logic              sdram_wr,
  output logic [7:0]        sdram_din,
  input  logic [7:0]        sdram_dout,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] SRC_VID = 2'd0;
  localparam logic [1:0] SRC_CPU = 2'd1;
  localparam logic [1:0] SRC_DL  = 2'd2;

  localparam logic [3:0] CNT_LOAD   = 4'(ACC_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state, next_state;
  logic [1:0] owner, winner;
  logic       any_req, cpu_first, cur_we;
  logic [3:0] strobe_cnt, starve_cnt;

  always_ff @(posedge F14M or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // A starved CPU jumps ahead of download but never ahead of video.
  always_comb begin
    any_req   = vid_req | cpu_req | dl_req;
    cpu_first = cpu_req && (starve_cnt >= STARVE_LIM);
    if (vid_req)                  winner = SRC_VID;
    else if (cpu_first || !dl_req) winner = SRC_CPU;
    else                          winner = SRC_DL;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (any_req) next_state = ST_STROBE;
      ST_STROBE: if (strobe_cnt == 4'd0) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sdram_rd = (state == ST_STROBE) && !cur_we;
    sdram_wr = (state == ST_STROBE) &&  cur_we;
    vid_ack  = (state == ST_DONE) && (owner == SRC_VID);
    cpu_ack  = (state == ST_DONE) && (owner == SRC_CPU);
    dl_ack   = (state == ST_DONE) && (owner == SRC_DL);
    busy     = (state != ST_IDLE);
  end

  always_ff @(posedge F14M or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= SRC_VID;
      cur_we     <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= '0;
      strobe_cnt <= '0;
      starve_cnt <= '0;
      vid_data   <= '0;
      cpu_dout   <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        owner      <= winner;
        strobe_cnt <= CNT_LOAD;
        case (winner)
          SRC_VID: begin
            sdram_addr <= vid_addr;
            cur_we     <= 1'b0;
          end
          SRC_CPU: begin
            sdram_addr <= cpu_addr;
            sdram_din  <= cpu_din;
            cur_we     <= cpu_we;
            starve_cnt <= '0;
          end
          default: begin
            sdram_addr <= dl_addr;
            sdram_din  <= dl_data;
            cur_we     <= 1'b1;
            if (cpu_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
          end
        endcase
      end
      // Read data lands on the last strobe edge so it is valid alongside the ack.
      if (state == ST_STROBE) begin
        if (strobe_cnt != 4'd0) begin
          strobe_cnt <= strobe_cnt - 4'd1;
        end else if (!cur_we) begin
          if (owner == SRC_VID) vid_data <= sdram_dout;
          if (owner == SRC_CPU) cpu_dout <= sdram_dout;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser500_ram_arbiter.sv
`default_nettype none
// Randomized bench for laser500_ram_arbiter: a transaction-level arbiter model
// pushes expected accesses at grant time; a monitor checks strobes and acks.
module tb_laser500_ram_arbiter;
  localparam int AW  = 25;
  localparam int ACC = 2;
  localparam int SMX = 4;

  logic F14M = 1'b0, reset_n = 1'b0;
  logic vid_req = 0, cpu_req = 0, cpu_we = 0, dl_req = 0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0, dl_addr = '0;
  logic [7:0] cpu_din = '0, dl_data = '0, sdram_dout = '0;
  logic vid_ack, cpu_ack, dl_ack, sdram_rd, sdram_wr, busy;
  logic [7:0] vid_data, cpu_dout, sdram_din;
  logic [AW-1:0] sdram_addr;

  laser500_ram_arbiter #(.ADDR_W(AW), .ACC_CYCLES(ACC), .STARVE_MAX(SMX)) dut (
    .F14M(F14M), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
    .sdram_din(sdram_din), .sdram_dout(sdram_dout), .busy(busy));

  always #5 F14M = ~F14M;

  typedef struct {
    int           who;   // 0 video, 1 cpu, 2 download
    logic [AW-1:0] addr;
    logic         we;
    logic [7:0]   wd;
    int           g;
  } txn_t;

  txn_t q[$];
  int errors = 0, checks = 0;
  int cyc = 0, mbusy = 0, starve = 0, scnt = 0;
  int nvid = 0, ncpu = 0, ndl = 0;
  logic [7:0] exp_vid = 8'h00, exp_cpu = 8'h00;
  logic run = 0, stop = 0;

  function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference arbiter: one access at a time, each occupying ACC+2 cycles.
  initial forever begin
    @(posedge F14M);
    if (reset_n) begin
      if (mbusy == 0) begin
        int order[3];
        int w;
        txn_t t;
        bit promote;
        promote = cpu_req && (starve >= SMX);
        order = promote ? '{0, 1, 2} : '{0, 2, 1};
        w = -1;
        for (int i = 0; i < 3; i++) begin
          if (w < 0 && ((order[i] == 0 && vid_req) || (order[i] == 1 && cpu_req) ||
                        (order[i] == 2 && dl_req)))
            w = order[i];
        end
        if (w >= 0) begin
          t.who = w; t.g = cyc;
          t.addr = (w == 0) ? vid_addr : (w == 1) ? cpu_addr : dl_addr;
          t.we   = (w == 0) ? 1'b0 : (w == 1) ? cpu_we : 1'b1;
          t.wd   = (w == 1) ? cpu_din : dl_data;
          q.push_back(t);
          mbusy = ACC + 1;
          if (w == 1) starve = 0;
          if (w == 2 && cpu_req) starve = (starve < 15) ? starve + 1 : 15;
        end
      end else begin
        mbusy--;
      end
    end
    cyc++;
  end

  // Monitor: compares strobes and acks against the head of the expected queue.
  initial forever begin
    @(negedge F14M);
    if (reset_n) begin
      txn_t t;
      int na, who;
      chk("busy", busy, (q.size() != 0));
      if (sdram_rd || sdram_wr) begin
        if (q.size() == 0) chk("strobe_unexpected", 1, 0);
        else begin
          t = q[0];
          chk("strobe_addr", sdram_addr, t.addr);
          chk("strobe_dir", {sdram_rd, sdram_wr}, t.we ? 2'b01 : 2'b10);
          if (t.we) chk("strobe_din", sdram_din, t.wd);
        end
        scnt++;
      end
      // Valid read data only on the final strobe cycle; garbage otherwise.
      sdram_dout = (sdram_rd && scnt == ACC) ? mem_f(sdram_addr) : 8'($urandom);
      na = int'(vid_ack) + int'(cpu_ack) + int'(dl_ack);
      if (na != 0) begin
        chk("ack_onehot", na, 1);
        if (q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          t = q.pop_front();
          who = vid_ack ? 0 : cpu_ack ? 1 : 2;
          chk("ack_who", who, t.who);
          chk("ack_latency", cyc - t.g, ACC + 1);
          chk("strobe_len", scnt, ACC);
          if (!t.we && t.who == 0) exp_vid = mem_f(t.addr);
          if (!t.we && t.who == 1) exp_cpu = mem_f(t.addr);
          chk("vid_data", vid_data, exp_vid);
          chk("cpu_dout", cpu_dout, exp_cpu);
          if (who == 0) nvid++; else if (who == 1) ncpu++; else ndl++;
        end
        scnt = 0;
      end
    end
  end

  initial begin
    wait (run);
    while (!stop) begin
      @(negedge F14M);
      if (vid_req && vid_ack) begin
        if ($urandom_range(0, 1) == 0) vid_req = 0; else vid_addr = rand_addr();
      end else if (!vid_req && $urandom_range(0, 7) == 0) begin
        vid_req = 1; vid_addr = rand_addr();
      end
    end
    vid_req = 0;
  end

  initial begin
    wait (run);
    while (!stop) begin
      @(negedge F14M);
      if ((cpu_req && cpu_ack) || (!cpu_req && $urandom_range(0, 2) == 0)) begin
        cpu_req  = (cpu_req && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
        cpu_we   = 1'($urandom);
        cpu_addr = rand_addr();
        cpu_din  = 8'($urandom);
      end
    end
    cpu_req = 0;
  end

  initial begin
    wait (run);
    while (!stop) begin
      @(negedge F14M);
      if ((dl_req && dl_ack) || (!dl_req && $urandom_range(0, 1) == 0)) begin
        dl_req  = (dl_req && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        dl_addr = rand_addr();
        dl_data = 8'($urandom);
      end
    end
    dl_req = 0;
  end

  initial begin
    int k;
    bit got;
    vid_req = 1; cpu_req = 1; dl_req = 1;
    vid_addr = rand_addr(); cpu_addr = rand_addr(); dl_addr = rand_addr();
    cpu_we = 0; cpu_din = 8'h3C; dl_data = 8'hC3;
    repeat (3) @(negedge F14M);
    chk("rst_strobes", {sdram_rd, sdram_wr}, 2'b00);
    chk("rst_acks", {vid_ack, cpu_ack, dl_ack}, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_din", sdram_din, 0);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    @(negedge F14M);
    reset_n = 1; run = 1;

    repeat (3000) @(negedge F14M);
    stop = 1;
    repeat (30) @(negedge F14M);
    chk("drained", q.size(), 0);
    chk("vid_served", (nvid > 0), 1);
    chk("cpu_served", (ncpu > 0), 1);
    chk("dl_served", (ndl > 0), 1);

    // Reset in the second strobe cycle of a download write.
    dl_req = 1; dl_addr = 25'h0089A5; dl_data = 8'h77;
    k = 0;
    for (int i = 0; i < 40 && k < 2; i++) begin
      @(posedge F14M); #2;
      if (sdram_wr) k++;
    end
    chk("mid_reset_reached", k, 2);
    reset_n = 0;
    #1;
    chk("mid_reset_wr", sdram_wr, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_ack", dl_ack, 0);
    q.delete(); mbusy = 0; starve = 0; scnt = 0; exp_vid = 8'h00; exp_cpu = 8'h00;
    got = 0;
    repeat (3) begin
      @(negedge F14M);
      if (dl_ack) got = 1;
    end
    chk("reset_no_ack", got, 0);
    reset_n = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge F14M);
      if (dl_ack) got = 1;
    end
    chk("reissue_ack", got, 1);
    dl_req = 0;
    repeat (10) @(negedge F14M);
    chk("final_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
